// File: rtl/lz77_token_compressor_if.sv
// Byte-in / token-out stream bundle for the LZ77 token compressor.
// The master side is the byte source plus token sink; the slave side is
// the compressor itself.
interface lz77_token_compressor_if #(
  parameter int TOKEN_BITS = 17
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [TOKEN_BITS-1:0] tok_data;
  logic                  tok_valid;
  logic                  tok_ready;
  logic                  tok_last;

  modport master (
    output in_data, in_valid, in_last, tok_ready,
    input  in_ready, tok_data, tok_valid, tok_last
  );

  modport slave (
    input  in_data, in_valid, in_last, tok_ready,
    output in_ready, tok_data, tok_valid, tok_last
  );
endinterface

// File: rtl/lz77_token_compressor.sv
// LZ77 compressor: buffers a lookahead, searches the history window with
// LANES parallel candidate distances per pass, and emits one fixed-width
// literal or match token per step with valid/ready backpressure.
module lz77_token_compressor #(
  parameter int WINDOW_DEPTH    = 1024,
  parameter int LOOKAHEAD_DEPTH = 32,
  parameter int MIN_MATCH       = 3,
  parameter int LANES           = 16,
  parameter int OFFSET_BITS     = $clog2(WINDOW_DEPTH),
  parameter int LENGTH_BITS     = $clog2(LOOKAHEAD_DEPTH) + 1,
  localparam int TOKEN_BITS     = 1 + OFFSET_BITS + LENGTH_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OFFSET_BITS:0]   cfg_max_dist,
  output logic                   busy,
  output logic                   done,
  lz77_token_compressor_if.slave bus,
  output logic [31:0]            bytes_in,
  output logic [31:0]            tokens_out
);

  localparam int LAW = $clog2(LOOKAHEAD_DEPTH);
  localparam int DW  = OFFSET_BITS + 2;

  typedef enum logic [2:0] {IDLE, FILL, SEARCH, EMIT, COMMIT, DONE} state_t;

  state_t                  state;
  logic [7:0]              window    [WINDOW_DEPTH];
  logic [7:0]              lookahead [LOOKAHEAD_DEPTH];
  logic [OFFSET_BITS-1:0]  wrPtr;
  logic [OFFSET_BITS:0]    winCount;
  logic [OFFSET_BITS:0]    maxDist;
  logic [LAW-1:0]          laHead;
  logic [LENGTH_BITS-1:0]  laCount;
  logic                    lastSeen;
  logic [DW-1:0]           baseDist;
  logic [LENGTH_BITS-1:0]  laneLen [LANES];
  logic [LENGTH_BITS-1:0]  bestLen;
  logic [DW-1:0]           bestDist;
  logic [LENGTH_BITS-1:0]  commitLeft;
  logic [TOKEN_BITS-1:0]   tokData;
  logic                    tokValid;
  logic                    tokLast;

  logic [DW-1:0]           limit;
  logic [DW-1:0]           searchDepth;
  logic [DW-1:0]           laneDist [LANES];
  logic [LANES-1:0]        laneCont;
  logic                    anyCont;
  logic [LENGTH_BITS-1:0]  finalLen;
  logic [DW-1:0]           finalDist;
  logic                    isMatch;
  logic [LENGTH_BITS-1:0]  consumed;
  logic                    lastGroup;
  logic [TOKEN_BITS-1:0]   nextToken;
  logic                    inAccept;

  assign bus.tok_data  = tokData;
  assign bus.tok_valid = tokValid;
  assign bus.tok_last  = tokLast;
  assign bus.in_ready  = (state == FILL) && (laCount < LENGTH_BITS'(LOOKAHEAD_DEPTH)) && !lastSeen;
  assign inAccept      = bus.in_valid && bus.in_ready;

  // Per-lane compare: a lane extends while the bytes agree, the lookahead
  // still has data, and the match would not overlap its own source.
  always_comb begin
    limit       = (maxDist == '0) ? DW'(WINDOW_DEPTH) : DW'(maxDist);
    searchDepth = (DW'(winCount) < limit) ? DW'(winCount) : limit;
    anyCont     = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      laneDist[k] = baseDist + DW'(k + 1);
      laneCont[k] = (laneDist[k] <= searchDepth) &&
                    (laneLen[k] < laCount) &&
                    (DW'(laneLen[k]) < laneDist[k]) &&
                    (window[OFFSET_BITS'(wrPtr + OFFSET_BITS'(laneLen[k]) - OFFSET_BITS'(laneDist[k]))] ==
                     lookahead[LAW'(laHead + LAW'(laneLen[k]))]);
      anyCont     = anyCont | laneCont[k];
    end
  end

  // Merge the pass winner into the running best; strict compare keeps the
  // smallest distance on equal length since lanes and groups ascend in d.
  always_comb begin
    finalLen  = bestLen;
    finalDist = bestDist;
    for (int k = 0; k < LANES; k++) begin
      if (laneLen[k] > finalLen) begin
        finalLen  = laneLen[k];
        finalDist = laneDist[k];
      end
    end
    isMatch   = finalLen >= LENGTH_BITS'(MIN_MATCH);
    consumed  = isMatch ? finalLen : LENGTH_BITS'(1);
    lastGroup = (baseDist + DW'(LANES)) >= searchDepth;
    nextToken = isMatch ? {1'b0, OFFSET_BITS'(finalDist - DW'(1)), finalLen}
                        : {1'b1, lookahead[laHead], {(OFFSET_BITS + LENGTH_BITS - 8){1'b0}}};
  end

  // Byte storage: lookahead fills at the tail, window receives committed
  // bytes and overwrites the oldest entry once it has wrapped.
  always_ff @(posedge clk) begin
    if (!rst && inAccept)
      lookahead[LAW'(laHead + LAW'(laCount))] <= bus.in_data;
    if (!rst && state == COMMIT)
      window[wrPtr] <= lookahead[laHead];
  end

  // Control FSM, counters and registered token outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_in   <= '0;
      tokens_out <= '0;
      wrPtr      <= '0;
      winCount   <= '0;
      maxDist    <= '0;
      laHead     <= '0;
      laCount    <= '0;
      lastSeen   <= 1'b0;
      baseDist   <= '0;
      bestLen    <= '0;
      bestDist   <= '0;
      commitLeft <= '0;
      tokData    <= '0;
      tokValid   <= 1'b0;
      tokLast    <= 1'b0;
      for (int k = 0; k < LANES; k++) laneLen[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FILL;
            busy       <= 1'b1;
            done       <= 1'b0;
            maxDist    <= cfg_max_dist;
            bytes_in   <= '0;
            tokens_out <= '0;
            wrPtr      <= '0;
            winCount   <= '0;
            laHead     <= '0;
            laCount    <= '0;
            lastSeen   <= 1'b0;
          end
        end
        FILL: begin
          if (inAccept) begin
            laCount  <= laCount + 1'b1;
            bytes_in <= bytes_in + 32'd1;
            if (bus.in_last) lastSeen <= 1'b1;
          end
          if (laCount == LENGTH_BITS'(LOOKAHEAD_DEPTH) || (lastSeen && laCount != '0)) begin
            state    <= SEARCH;
            baseDist <= '0;
            bestLen  <= '0;
            bestDist <= '0;
            for (int k = 0; k < LANES; k++) laneLen[k] <= '0;
          end else if (lastSeen) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        SEARCH: begin
          if (anyCont) begin
            for (int k = 0; k < LANES; k++)
              if (laneCont[k]) laneLen[k] <= laneLen[k] + 1'b1;
          end else begin
            bestLen  <= finalLen;
            bestDist <= finalDist;
            if (finalLen == laCount || lastGroup) begin
              state      <= EMIT;
              tokData    <= nextToken;
              tokValid   <= 1'b1;
              tokLast    <= lastSeen && (consumed == laCount);
              commitLeft <= consumed;
            end else begin
              baseDist <= baseDist + DW'(LANES);
              for (int k = 0; k < LANES; k++) laneLen[k] <= '0;
            end
          end
        end
        EMIT: begin
          if (bus.tok_ready) begin
            state      <= COMMIT;
            tokValid   <= 1'b0;
            tokLast    <= 1'b0;
            tokens_out <= tokens_out + 32'd1;
          end
        end
        COMMIT: begin
          laHead     <= laHead + 1'b1;
          wrPtr      <= wrPtr + 1'b1;
          laCount    <= laCount - 1'b1;
          commitLeft <= commitLeft - 1'b1;
          if (winCount != (OFFSET_BITS + 1)'(WINDOW_DEPTH)) winCount <= winCount + 1'b1;
          if (commitLeft == LENGTH_BITS'(1)) begin
            if (lastSeen && laCount == LENGTH_BITS'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (lastSeen) begin
              state    <= SEARCH;
              baseDist <= '0;
              bestLen  <= '0;
              bestDist <= '0;
              for (int k = 0; k < LANES; k++) laneLen[k] <= '0;
            end else begin
              state <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_token_compressor.sv
// Directed testbench for lz77_token_compressor: literal-only streams,
// matches with tie-break, short matches, backpressure, reset mid-search
// and a long stream that wraps the window, decoded back to the source.
module tb_lz77_token_compressor;

  localparam int WD = 1024;
  localparam int LA = 32;
  localparam int TB = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [10:0]   cfgMaxDist;
  logic          busy;
  logic          done;
  logic [31:0]   bytesIn;
  logic [31:0]   tokensOut;

  int            checks = 0;
  int            errors = 0;
  bit            timedOut;
  logic [7:0]    srcQ[$];
  logic [TB-1:0] tokQ[$];
  bit            lastQ[$];

  lz77_token_compressor_if #(.TOKEN_BITS(TB)) bus ();

  lz77_token_compressor #(
    .WINDOW_DEPTH(WD), .LOOKAHEAD_DEPTH(LA), .MIN_MATCH(3), .LANES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_max_dist(cfgMaxDist),
    .busy(busy), .done(done), .bus(bus),
    .bytes_in(bytesIn), .tokens_out(tokensOut)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic logic [TB-1:0] lit(input logic [7:0] b);
    return {1'b1, b, 8'h00};
  endfunction

  function automatic logic [TB-1:0] mt(input int off, input int len);
    return {1'b0, 10'(off), 6'(len)};
  endfunction

  task automatic loadString(input string s);
    srcQ.delete();
    for (int i = 0; i < s.len(); i++) srcQ.push_back(s[i]);
  endtask

  // Starts a stream, feeds srcQ and collects every handshaken token until done.
  task automatic runStream(input logic [10:0] cfg);
    tokQ.delete();
    lastQ.delete();
    timedOut = 1'b0;
    @(negedge clk);
    cfgMaxDist = cfg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    fork
      begin
        for (int i = 0; i < srcQ.size(); i++) begin
          int waited;
          waited = 0;
          bus.in_data  = srcQ[i];
          bus.in_last  = (i == srcQ.size() - 1);
          bus.in_valid = 1'b1;
          @(negedge clk);
          while (!bus.in_ready && waited < 30000) begin
            @(negedge clk);
            waited++;
          end
          if (!bus.in_ready) begin
            timedOut = 1'b1;
            break;
          end
          @(posedge clk);
          #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
      begin
        int c;
        c = 0;
        bus.tok_ready = 1'b1;
        while (c < 30000) begin
          @(negedge clk);
          c++;
          if (done) break;
          if (bus.tok_valid) begin
            tokQ.push_back(bus.tok_data);
            lastQ.push_back(bus.tok_last);
          end
        end
        if (!done) timedOut = 1'b1;
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bus.in_ready, bus.tok_valid, bus.tok_last, bus.tok_data, bytesIn, tokensOut} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b in_ready=%b tok_valid=%b tok_last=%b tok_data=%h bytes_in=%0d tokens_out=%0d, expected all zero",
               busy, done, bus.in_ready, bus.tok_valid, bus.tok_last, bus.tok_data, bytesIn, tokensOut);
    end
    rst = 1'b0;
  endtask

  task automatic test_literals();
    logic [TB-1:0] expTok[4];
    expTok = '{lit(8'h41), lit(8'h42), lit(8'h43), lit(8'h44)};
    loadString("ABCD");
    runStream(11'd0);
    checks++;
    if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL abcd_timeout: got timeout, expected stream to complete"); end
    checks++;
    if (tokQ.size() != 4) begin errors++; $display("[TB] FAIL abcd_count: got %0d tokens, expected 4", tokQ.size()); end
    for (int i = 0; i < 4 && i < tokQ.size(); i++) begin
      checks++;
      if (tokQ[i] !== expTok[i]) begin errors++; $display("[TB] FAIL abcd_token%0d: got %h expected %h", i, tokQ[i], expTok[i]); end
      checks++;
      if (lastQ[i] !== (i == 3)) begin errors++; $display("[TB] FAIL abcd_last%0d: got %b expected %b", i, lastQ[i], (i == 3)); end
    end
    checks++;
    if (bytesIn !== 32'd4 || tokensOut !== 32'd4) begin
      errors++; $display("[TB] FAIL abcd_counters: got bytes_in=%0d tokens_out=%0d expected 4/4", bytesIn, tokensOut);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abcd_status: got done=%b busy=%b expected 1/0", done, busy); end
  endtask

  task automatic test_matches();
    logic [TB-1:0] expTok[5];
    expTok = '{lit(8'h41), lit(8'h42), lit(8'h43), mt(2, 3), mt(2, 3)};
    loadString("ABCABCABC");
    runStream(11'd0);
    checks++;
    if (timedOut !== 1'b0 || tokQ.size() != 5) begin
      errors++; $display("[TB] FAIL abc_count: got %0d tokens (timeout=%b), expected 5", tokQ.size(), timedOut);
    end
    for (int i = 0; i < 5 && i < tokQ.size(); i++) begin
      checks++;
      if (tokQ[i] !== expTok[i]) begin errors++; $display("[TB] FAIL abc_token%0d: got %h expected %h", i, tokQ[i], expTok[i]); end
      checks++;
      if (lastQ[i] !== (i == 4)) begin errors++; $display("[TB] FAIL abc_last%0d: got %b expected %b", i, lastQ[i], (i == 4)); end
    end
    checks++;
    if (bytesIn !== 32'd9 || tokensOut !== 32'd5) begin
      errors++; $display("[TB] FAIL abc_counters: got bytes_in=%0d tokens_out=%0d expected 9/5", bytesIn, tokensOut);
    end
  endtask

  task automatic test_short_match();
    string s;
    s = "ABXAB";
    loadString(s);
    runStream(11'd0);
    checks++;
    if (timedOut !== 1'b0 || tokQ.size() != 5) begin
      errors++; $display("[TB] FAIL abxab_count: got %0d tokens (timeout=%b), expected 5", tokQ.size(), timedOut);
    end
    for (int i = 0; i < 5 && i < tokQ.size(); i++) begin
      checks++;
      if (tokQ[i] !== lit(s[i])) begin errors++; $display("[TB] FAIL abxab_token%0d: got %h expected %h", i, tokQ[i], lit(s[i])); end
    end
  endtask

  task automatic test_backpressure();
    string s;
    int waited;
    int extra;
    s = "ABCD";
    bus.tok_ready = 1'b0;
    @(negedge clk);
    cfgMaxDist = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = s[i];
      bus.in_last  = (i == 3);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!bus.tok_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.tok_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid: got tok_valid=%b expected 1", bus.tok_valid); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.tok_valid, bus.tok_data, bus.in_ready, tokensOut} !== {1'b1, lit(8'h41), 1'b0, 32'd0}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h in_ready=%b tokens_out=%0d expected 1/%h/0/0",
                 c, bus.tok_valid, bus.tok_data, bus.in_ready, tokensOut, lit(8'h41));
      end
    end
    bus.tok_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tokensOut !== 32'd1 || bus.tok_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: got tokens_out=%0d tok_valid=%b expected 1/0", tokensOut, bus.tok_valid);
    end
    extra = 0;
    waited = 0;
    while (!done && waited < 500) begin
      @(negedge clk);
      waited++;
      if (bus.tok_valid && !done) extra++;
    end
    checks++;
    if (done !== 1'b1 || extra != 3 || tokensOut !== 32'd4) begin
      errors++; $display("[TB] FAIL bp_finish: got done=%b remaining=%0d tokens_out=%0d expected 1/3/4", done, extra, tokensOut);
    end
  endtask

  task automatic test_reset_mid_search();
    string s;
    s = "ABCD";
    bus.tok_ready = 1'b1;
    @(negedge clk);
    cfgMaxDist = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = s[i];
      bus.in_last  = (i == 3);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bus.in_ready, bus.tok_valid, bus.tok_last, bus.tok_data, bytesIn, tokensOut} !== '0) begin
      errors++;
      $display("[TB] FAIL midsearch_reset: got busy=%b done=%b in_ready=%b tok_valid=%b tok_data=%h bytes_in=%0d tokens_out=%0d, expected all zero",
               busy, done, bus.in_ready, bus.tok_valid, bus.tok_data, bytesIn, tokensOut);
    end
    rst = 1'b0;
    loadString("AAAA");
    runStream(11'd0);
    checks++;
    if (timedOut !== 1'b0 || tokQ.size() != 4) begin
      errors++; $display("[TB] FAIL aaaa_count: got %0d tokens (timeout=%b), expected 4", tokQ.size(), timedOut);
    end
    for (int i = 0; i < 4 && i < tokQ.size(); i++) begin
      checks++;
      if (tokQ[i] !== lit(8'h41)) begin errors++; $display("[TB] FAIL aaaa_token%0d: got %h expected %h", i, tokQ[i], lit(8'h41)); end
    end
    checks++;
    if (bytesIn !== 32'd4 || tokensOut !== 32'd4) begin
      errors++; $display("[TB] FAIL aaaa_counters: got bytes_in=%0d tokens_out=%0d expected 4/4", bytesIn, tokensOut);
    end
  endtask

  task automatic test_window_wrap(input logic [10:0] cfg);
    logic [7:0] decoded[$];
    int lim, distBad, dataBad, lastBad;
    lim = (cfg == 0) ? WD : int'(cfg);
    distBad = 0;
    dataBad = 0;
    lastBad = 0;
    srcQ.delete();
    for (int i = 0; i < 1100; i++) srcQ.push_back(8'(i % 7));
    runStream(cfg);
    checks++;
    if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL wrap%0d_timeout: got timeout, expected completion", cfg); end
    foreach (tokQ[t]) begin
      if (tokQ[t][16]) begin
        decoded.push_back(tokQ[t][15:8]);
      end else begin
        int d, len, base;
        d    = int'(tokQ[t][15:6]) + 1;
        len  = int'(tokQ[t][5:0]);
        base = decoded.size() - d;
        if (d > lim || len < 3 || len > d || base < 0) distBad++;
        else for (int j = 0; j < len; j++) decoded.push_back(decoded[base + j]);
      end
      if (lastQ[t] !== (t == tokQ.size() - 1)) lastBad++;
    end
    checks++;
    if (distBad != 0) begin errors++; $display("[TB] FAIL wrap%0d_distance: got %0d bad match tokens, expected 0 (limit %0d)", cfg, distBad, lim); end
    checks++;
    if (decoded.size() != 1100) begin errors++; $display("[TB] FAIL wrap%0d_length: got %0d decoded bytes expected 1100", cfg, decoded.size()); end
    for (int i = 0; i < decoded.size() && i < 1100; i++) if (decoded[i] !== srcQ[i]) dataBad++;
    checks++;
    if (dataBad != 0) begin errors++; $display("[TB] FAIL wrap%0d_data: got %0d differing bytes expected 0", cfg, dataBad); end
    checks++;
    if (lastBad != 0) begin errors++; $display("[TB] FAIL wrap%0d_last: got %0d misplaced tok_last expected 0", cfg, lastBad); end
    checks++;
    if (bytesIn !== 32'd1100 || tokensOut !== 32'(tokQ.size())) begin
      errors++; $display("[TB] FAIL wrap%0d_counters: got bytes_in=%0d tokens_out=%0d expected 1100/%0d", cfg, bytesIn, tokensOut, tokQ.size());
    end
    checks++;
    if (cfg == 11'd5 ? (tokQ.size() != 1100) : (tokQ.size() >= 1100)) begin
      errors++; $display("[TB] FAIL wrap%0d_tokens: got %0d tokens, expected %s", cfg, tokQ.size(), (cfg == 11'd5) ? "1100 literals" : "fewer than 1100");
    end
  endtask

  // Runs every scenario in sequence and prints the summary.
  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    cfgMaxDist    = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.tok_ready = 1'b0;
    test_reset();
    test_literals();
    test_matches();
    test_short_match();
    test_backpressure();
    test_reset_mid_search();
    test_window_wrap(11'd5);
    test_window_wrap(11'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
